// File: rtl/vga_pkg.sv
// Shared definitions for the VGA square-drawing path.
// Contents:
//   H_ACTIVE / V_ACTIVE   visible area of the 640x480 mode
//   X_W_DEF / Y_W_DEF     default pixel coordinate widths
//   BLACK/RED/GREEN/BLUE  3-bit {R,G,B} colour codes
//   state_t               scheduler FSM states
//   chan()                expands one colour-code bit to a 3-bit VGA channel
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int X_W_DEF  = 10;
  localparam int Y_W_DEF  = 9;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  function automatic logic [2:0] chan(input logic bit_in);
    return {3{bit_in}};
  endfunction

endpackage

// File: rtl/square_hit.sv
// Combinational hit test for one square object.
// Ports:
//   i_ox, i_oy  top-left corner of the square
//   i_en        object visible
//   i_x, i_y    current pixel
//   o_hit       pixel lies inside the enabled square
// Comparisons run one bit wider than the coordinates so that
// corner+SIZE never wraps back into the low range.
module square_hit #(
  parameter int X_W  = 10,
  parameter int Y_W  = 9,
  parameter int SIZE = 160
) (
  input  logic [X_W-1:0] i_ox,
  input  logic [Y_W-1:0] i_oy,
  input  logic           i_en,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic           o_hit
);

  logic [X_W:0] w_x;
  logic [X_W:0] w_ox;
  logic [X_W:0] w_x_end;
  logic [Y_W:0] w_y;
  logic [Y_W:0] w_oy;
  logic [Y_W:0] w_y_end;

  assign w_x     = {1'b0, i_x};
  assign w_ox    = {1'b0, i_ox};
  assign w_x_end = w_ox + (X_W+1)'(SIZE);
  assign w_y     = {1'b0, i_y};
  assign w_oy    = {1'b0, i_oy};
  assign w_y_end = w_oy + (Y_W+1)'(SIZE);

  assign o_hit = i_en & (w_x >= w_ox) & (w_x < w_x_end)
                      & (w_y >= w_oy) & (w_y < w_y_end);

endmodule

// File: rtl/square_scheduler.sv
// Frame-synchronous square scheduler.
// Updates land in a shadow bank and are copied to the active bank one
// object per clock starting at the vblank rise, so a visible frame never
// mixes old and new positions. A two-stage pixel pipeline (hit vector,
// then priority-resolved colour) advances on each pixel strobe.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_pix_stb                 pixel enable (one i_clk wide)
//   i_x, i_y, i_vblank        timing generator position / blanking
//   i_upd_*/o_upd_ready       object update handshake
//   o_red, o_green, o_blue    VGA channels (2 strobes after i_x/i_y)
//   o_pending                 shadow bank holds uncommitted updates
//   o_dbg_state               FSM state, for observation
// Handshake: an update transfers on a clock edge where i_upd_valid and
// o_upd_ready are both high; ready is high whenever the FSM is IDLE and
// does not depend on valid. The id port carries one extra bit so that
// out-of-range ids can be posted; those are accepted and dropped.
module square_scheduler
  import vga_pkg::*;
#(
  parameter int N_OBJ  = 4,
  parameter int SIZE   = 160,
  parameter int X_W    = X_W_DEF,
  parameter int Y_W    = Y_W_DEF,
  localparam int ID_W  = $clog2(N_OBJ) + 1,
  localparam int IDX_W = $clog2(N_OBJ)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pix_stb,
  input  logic [X_W-1:0]  i_x,
  input  logic [Y_W-1:0]  i_y,
  input  logic            i_vblank,
  input  logic            i_upd_valid,
  output logic            o_upd_ready,
  input  logic [ID_W-1:0] i_upd_id,
  input  logic [X_W-1:0]  i_upd_x,
  input  logic [Y_W-1:0]  i_upd_y,
  input  logic            i_upd_en,
  input  logic [2:0]      i_upd_color,
  output logic [2:0]      o_red,
  output logic [2:0]      o_green,
  output logic [2:0]      o_blue,
  output logic            o_pending,
  output state_t          o_dbg_state
);

  // shadow and active banks
  logic [X_W-1:0] r_sh_x  [N_OBJ];
  logic [Y_W-1:0] r_sh_y  [N_OBJ];
  logic           r_sh_en [N_OBJ];
  logic [2:0]     r_sh_c  [N_OBJ];
  logic [X_W-1:0] r_ac_x  [N_OBJ];
  logic [Y_W-1:0] r_ac_y  [N_OBJ];
  logic           r_ac_en [N_OBJ];
  logic [2:0]     r_ac_c  [N_OBJ];

  state_t           r_state;
  state_t           w_state_nx;
  logic [IDX_W-1:0] r_idx;
  logic             r_dirty;
  logic             r_vb_q;
  logic             w_vb_rise;
  logic             w_acc;
  logic             w_acc_valid;
  logic             w_copy;
  logic             w_last;

  logic [N_OBJ-1:0] w_hit;
  logic [N_OBJ-1:0] r_hit;
  logic             w_active;
  logic             r_active;
  logic [2:0]       w_color;
  logic [2:0]       r_rgb;

  assign w_vb_rise   = i_vblank & ~r_vb_q;
  assign w_acc       = i_upd_valid & o_upd_ready;
  assign w_acc_valid = w_acc & (i_upd_id < ID_W'(N_OBJ));
  assign w_last      = (r_idx == IDX_W'(N_OBJ - 1));

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  // FSM: next state. An update accepted on the vblank-rise clock already
  // sits in the shadow bank when copying starts, so it also triggers.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_vb_rise && (r_dirty || w_acc_valid)) w_state_nx = COMMIT;
      COMMIT:  if (w_last) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_upd_ready = 1'b0;
    w_copy      = 1'b0;
    case (r_state)
      IDLE:    o_upd_ready = 1'b1;
      COMMIT:  w_copy      = 1'b1;
      default: o_upd_ready = 1'b0;
    endcase
  end

  // banks, copy index, dirty flag, vblank edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_dirty <= 1'b0;
      r_vb_q  <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        r_sh_x[i] <= '0; r_sh_y[i] <= '0; r_sh_en[i] <= 1'b0; r_sh_c[i] <= '0;
        r_ac_x[i] <= '0; r_ac_y[i] <= '0; r_ac_en[i] <= 1'b0; r_ac_c[i] <= '0;
      end
    end else begin
      r_vb_q <= i_vblank;
      if (w_copy) r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      // ready is low during COMMIT, so set and clear never coincide
      if (w_copy && w_last)  r_dirty <= 1'b0;
      else if (w_acc_valid)  r_dirty <= 1'b1;
      for (int i = 0; i < N_OBJ; i++) begin
        if (w_acc_valid && (i_upd_id == ID_W'(i))) begin
          r_sh_x[i]  <= i_upd_x;
          r_sh_y[i]  <= i_upd_y;
          r_sh_en[i] <= i_upd_en;
          r_sh_c[i]  <= i_upd_color;
        end
        if (w_copy && (r_idx == IDX_W'(i))) begin
          r_ac_x[i]  <= r_sh_x[i];
          r_ac_y[i]  <= r_sh_y[i];
          r_ac_en[i] <= r_sh_en[i];
          r_ac_c[i]  <= r_sh_c[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
    square_hit #(.X_W(X_W), .Y_W(Y_W), .SIZE(SIZE)) u_hit (
      .i_ox (r_ac_x[g]),
      .i_oy (r_ac_y[g]),
      .i_en (r_ac_en[g]),
      .i_x  (i_x),
      .i_y  (i_y),
      .o_hit(w_hit[g])
    );
  end

  assign w_active = ({1'b0, i_x} < (X_W+1)'(H_ACTIVE)) & ~i_vblank;

  // lowest index wins: scan downward so the last assignment is the lowest hit
  always_comb begin
    w_color = BLACK;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (r_hit[i]) w_color = r_ac_c[i];
    end
    if (!r_active) w_color = BLACK;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit    <= '0;
      r_active <= 1'b0;
      r_rgb    <= BLACK;
    end else if (i_pix_stb) begin
      r_hit    <= w_hit;
      r_active <= w_active;
      r_rgb    <= w_color;
    end
  end

  assign o_red       = chan(r_rgb[2]);
  assign o_green     = chan(r_rgb[1]);
  assign o_blue      = chan(r_rgb[0]);
  assign o_pending   = r_dirty;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_square_scheduler.sv
module tb_square_scheduler;
  import vga_pkg::*;

  localparam int N_OBJ = 4;
  localparam int SIZE  = 160;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       pix_stb, vblank, upd_valid, upd_ready, upd_en, pending;
  logic [9:0] x, upd_x;
  logic [8:0] y, upd_y;
  logic [2:0] upd_id, upd_color, red, green, blue;
  state_t     dbg_state;

  square_scheduler #(.N_OBJ(N_OBJ), .SIZE(SIZE), .X_W(10), .Y_W(9)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_x(x), .i_y(y),
    .i_vblank(vblank), .i_upd_valid(upd_valid), .o_upd_ready(upd_ready),
    .i_upd_id(upd_id), .i_upd_x(upd_x), .i_upd_y(upd_y), .i_upd_en(upd_en),
    .i_upd_color(upd_color), .o_red(red), .o_green(green), .o_blue(blue),
    .o_pending(pending), .o_dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  int  sh_x[N_OBJ], sh_y[N_OBJ], sh_en[N_OBJ], sh_c[N_OBJ];
  int  ac_x[N_OBJ], ac_y[N_OBJ], ac_en[N_OBJ], ac_c[N_OBJ];
  bit  m_dirty;

  function automatic logic [2:0] model_color(int px, int py, bit vb);
    if (vb || px >= 640) return 3'b000;
    for (int i = 0; i < N_OBJ; i++)
      if (ac_en[i] != 0 && px >= ac_x[i] && px < ac_x[i] + SIZE &&
          py >= ac_y[i] && py < ac_y[i] + SIZE)
        return 3'(ac_c[i]);
    return 3'b000;
  endfunction

  function automatic logic [8:0] rgb9(logic [2:0] c);
    return {{3{c[2]}}, {3{c[1]}}, {3{c[0]}}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_OBJ; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; sh_c[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0; ac_c[i] = 0;
    end
    m_dirty = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pipe_reset();
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back(3'b000);
    tag_q.push_back("reset_stage1");
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one pixel with a strobe; compare the pixel presented one strobe
  // earlier, whose colour must now be on the outputs (2-strobe latency)
  task automatic pix(input int px, input int py);
    logic [2:0] e;
    string      t;
    x = 10'(px);
    y = 9'(py);
    exp_q.push_back(model_color(px, py, vblank));
    tag_q.push_back($sformatf("pix(%0d,%0d,vb=%0d)", px, py, vblank));
    pix_stb = 1'b1;
    tick();
    pix_stb = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {red, green, blue}, rgb9(e));
    tick(); tick(); tick();
  endtask

  task automatic post(input int id, input int ux, input int uy, input int en, input int c);
    int w;
    w = 0;
    while (!upd_ready && w < 50) begin tick(); w++; end
    check("ready_before_post", upd_ready, 1);
    upd_valid = 1'b1; upd_id = 3'(id); upd_x = 10'(ux); upd_y = 9'(uy);
    upd_en = 1'(en); upd_color = 3'(c);
    tick();
    upd_valid = 1'b0;
    if (id < N_OBJ) begin
      sh_x[id] = ux; sh_y[id] = uy; sh_en[id] = en; sh_c[id] = c;
      m_dirty = 1'b1;
    end
    check($sformatf("pending_after_post_id%0d", id), pending, m_dirty);
  endtask

  task automatic model_commit();
    for (int i = 0; i < N_OBJ; i++) begin
      ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_en[i] = sh_en[i]; ac_c[i] = sh_c[i];
    end
    m_dirty = 1'b0;
  endtask

  // count clocks with ready low after a vblank rise (bounded)
  task automatic count_ready_low(output int cnt);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (upd_ready) break;
      cnt++;
      tick();
    end
  endtask

  task automatic do_vblank();
    int cnt;
    int exp_cnt;
    pix(700, 10);
    pix(700, 11);
    exp_cnt = m_dirty ? N_OBJ : 0;
    vblank = 1'b1;
    tick();
    count_ready_low(cnt);
    check("commit_ready_low_clks", cnt, exp_cnt);
    check("pending_after_commit", pending, 0);
    if (m_dirty) model_commit();
    pix(300, 300);   // blanking pixel, always black
    vblank = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [2:0] held;

    rst_n = 1'b0; pix_stb = 1'b0; vblank = 1'b0; upd_valid = 1'b0;
    x = '0; y = '0; upd_id = '0; upd_x = '0; upd_y = '0; upd_en = 1'b0; upd_color = '0;
    model_reset();
    pipe_reset();
    #23;
    check("rst_rgb", {red, green, blue}, 9'd0);
    check("rst_ready", upd_ready, 1);
    check("rst_pending", pending, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    tick();

    // idle frame: all disabled -> black everywhere
    for (int i = 0; i < 6; i++) pix($urandom_range(0, 799), $urandom_range(0, 479));
    vblank = 1'b1;
    pix(100, 100);
    pix(639, 479);
    vblank = 1'b0;
    tick();
    check("idle_ready", upd_ready, 1);
    check("idle_pending", pending, 0);
    do_vblank();   // vblank rise with nothing pending: no commit

    // single update mid-frame: invisible until next vblank
    post(1, 200, 120, 1, RED);
    pix(250, 150);
    pix(250, 150);
    do_vblank();
    pix(250, 150);
    pix(250, 150);

    // overlap priority
    post(0, 120, 40, 1, GREEN);
    do_vblank();
    pix(250, 150); pix(300, 250); pix(120, 40); pix(280, 200); pix(279, 199);

    // boundary: bottom-right corner, clip at x=640, no y wrap of 400+160
    post(2, 600, 400, 1, BLUE);
    do_vblank();
    pix(639, 479); pix(640, 479); pix(799, 479); pix(620, 20); pix(600, 400); pix(599, 400);

    // out-of-range id: accepted, no effect
    post(5, 0, 0, 1, RED);
    check("oob_pending", pending, 0);
    do_vblank();
    pix(0, 0); pix(10, 10);

    // valid held across the vblank rise
    pix(700, 5); pix(700, 6);
    upd_valid = 1'b1; upd_id = 3'd3; upd_x = 10'd10; upd_y = 9'd10;
    upd_en = 1'b1; upd_color = BLUE;
    vblank = 1'b1;
    tick();
    sh_x[3] = 10; sh_y[3] = 10; sh_en[3] = 1; sh_c[3] = BLUE; m_dirty = 1'b1;
    count_ready_low(cnt);
    check("held_ready_low_clks", cnt, N_OBJ);
    check("held_pending_cleared", pending, 0);
    model_commit();
    tick();
    upd_valid = 1'b0;
    m_dirty = 1'b1;
    check("held_pending_reasserts", pending, 1);
    vblank = 1'b0;
    tick();
    pix(15, 15); pix(15, 15);
    do_vblank();

    // randomized rounds
    for (int r = 0; r < 3; r++) begin
      for (int u = 0; u < 5; u++)
        post($urandom_range(0, 5), $urandom_range(0, 799), $urandom_range(0, 479),
             $urandom_range(0, 1), $urandom_range(0, 7));
      do_vblank();
      for (int p = 0; p < 25; p++) pix($urandom_range(0, 799), $urandom_range(0, 479));
    end

    // async reset in the second copy clock of a commit
    post(2, 600, 400, 1, BLUE);
    do_vblank();
    pix(639, 479); pix(639, 479);
    held = model_color(639, 479, 1'b0);
    post(0, 50, 50, 1, RED);
    vblank = 1'b1;
    tick();
    tick();
    check("hold_rgb_between_strobes", {red, green, blue}, rgb9(held));
    check("commit_in_progress", upd_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb", {red, green, blue}, 9'd0);
    check("async_rst_ready", upd_ready, 1);
    check("async_rst_pending", pending, 0);
    check("async_rst_state", dbg_state, IDLE);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    vblank = 1'b0;
    model_reset();
    pipe_reset();
    tick();
    pix(639, 479); pix(60, 60); pix(0, 0);
    do_vblank();
    pix(639, 479); pix(639, 479);
    post(1, 0, 0, 1, GREEN);
    do_vblank();
    pix(0, 0); pix(159, 159); pix(160, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
